audio_limiter: RTL and testbench

Multi-channel, time-multiplexed audio peak limiter. It takes INPUT_WIDTH-bit signed samples tagged with a channel number and produces OUTPUT_WIDTH-bit signed samples of the same LSB weight. Two modes are selected by parameter: hard saturation only, or per-channel gain reduction with attack, release and envelope averaging. It sits at the end of the audio mixing chain, ahead of DAC or serializer output.

---
 rtl/limiter_pkg.sv | 33 +++
 rtl/limiter_sat.sv | 21 ++
 rtl/audio_limiter.sv | 214 +++++++++++++++++++++
 tb/tb_audio_limiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/limiter_pkg.sv
// Shared constants, helpers and FSM encoding for the audio limiter.
package limiter_pkg;

    localparam int GAIN_W    = 18;
    localparam int GAIN_FRAC = 16;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1 << GAIN_FRAC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_OUT
    } state_t;

    // Envelope level above which the gain is pulled down.
    function automatic int limiter_threshold(input int outw);
        return 1 << (outw - 2);
    endfunction

    // Clamp a sign-extended value into the signed range of an outw-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int outw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (outw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (outw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/limiter_sat.sv
// Combinational signed saturation from INW bits down to OUTW bits (same LSB weight).
module limiter_sat
    import limiter_pkg::*;
#(
    parameter int INW  = 30,
    parameter int OUTW = 24
) (
    input  logic signed [INW-1:0]  d,
    output logic signed [OUTW-1:0] q
);

    logic signed [63:0] wide;
    logic signed [63:0] clamped;
    logic               unused_hi;

    assign wide      = 64'(d);
    assign clamped   = saturate(wide, OUTW);
    assign q         = clamped[OUTW-1:0];
    assign unused_hi = ^clamped[63:OUTW];

endmodule

// File: rtl/audio_limiter.sv
// Time-multiplexed multi-channel peak limiter: hard saturation or per-channel gain limiting.
// Optional LIMITER_ROUND_EN: round the gain product half-up instead of truncating.
module audio_limiter
    import limiter_pkg::*;
#(
    parameter  int NR_CHANNELS       = 2,
    parameter  int INPUT_WIDTH       = 30,
    parameter  int OUTPUT_WIDTH      = 24,
    parameter  int ATTENUATION       = 0,
    parameter  int MAX_ATTACK_SHIFT  = 10,
    parameter  int MAX_RELEASE_SHIFT = 10,
    parameter  int MAX_AVG_SHIFT     = 3,
    localparam int INW = INPUT_WIDTH,
    localparam int OUTW = OUTPUT_WIDTH,
    localparam int CHW = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1,
    localparam int ASW = (MAX_ATTACK_SHIFT > 1) ? $clog2(MAX_ATTACK_SHIFT) : 1,
    localparam int RSW = (MAX_RELEASE_SHIFT > 1) ? $clog2(MAX_RELEASE_SHIFT) : 1,
    localparam int VSW = (MAX_AVG_SHIFT > 1) ? $clog2(MAX_AVG_SHIFT) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [INW-1:0]  signal_d,
    input  logic [CHW-1:0]         signal_ch,
    input  logic                   signal_dv,
    output logic                   signal_dr,
    input  logic [ASW-1:0]         attack_shift,
    input  logic [RSW-1:0]         release_shift,
    input  logic [VSW-1:0]         avg_shift,
    output logic signed [OUTW-1:0] lim_d,
    output logic [CHW-1:0]         lim_ch,
    output logic                   lim_dv
);

    logic                   dr_reg;
    logic                   lim_dv_reg;
    logic signed [OUTW-1:0] lim_d_reg;
    logic [CHW-1:0]         lim_ch_reg;

    assign signal_dr = dr_reg;
    assign lim_dv    = lim_dv_reg;
    assign lim_d     = lim_d_reg;
    assign lim_ch    = lim_ch_reg;

    if (ATTENUATION == 0) begin : g_sat_only
        logic signed [OUTW-1:0] sat_q;
        logic                   unused_ctrl;

        assign unused_ctrl = ^{attack_shift, release_shift, avg_shift};

        limiter_sat #(.INW(INW), .OUTW(OUTW)) u_sat (
            .d (signal_d),
            .q (sat_q)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dr_reg     <= 1'b0;
                lim_dv_reg <= 1'b0;
                lim_d_reg  <= '0;
                lim_ch_reg <= '0;
            end else begin
                dr_reg     <= 1'b1;
                lim_dv_reg <= signal_dv && dr_reg;
                if (signal_dv && dr_reg) begin
                    lim_d_reg  <= sat_q;
                    lim_ch_reg <= signal_ch;
                end
            end
        end
    end else begin : g_gain
        localparam int PW = INW + GAIN_W;
        localparam logic [OUTW-1:0] THRESHOLD = OUTW'(limiter_threshold(OUTW));
        localparam logic signed [OUTW-1:0] SMIN = {1'b1, {(OUTW-1){1'b0}}};
        localparam logic [OUTW-1:0] SMAX_U = {1'b0, {(OUTW-1){1'b1}}};

        state_t                 state_reg;
        logic signed [INW-1:0]  s_reg;
        logic [CHW-1:0]         ch_reg;
        logic signed [PW-1:0]   p_reg;

        logic [GAIN_W-1:0]      gain_arr [NR_CHANNELS];
        logic [OUTW-1:0]        env_arr  [NR_CHANNELS];
        logic                   ch_ok;
        logic [GAIN_W-1:0]      gain_rd;
        logic [OUTW-1:0]        env_rd;

        logic [ASW-1:0]         attack_c;
        logic [RSW-1:0]         release_c;
        logic [VSW-1:0]         avg_c;

        logic signed [PW-1:0]   p_next;
        logic signed [PW-1:0]   p_rnd;
        logic signed [PW-1:0]   p_shift;
        logic signed [OUTW-1:0] y;
        logic [OUTW-1:0]        mag;
        logic signed [OUTW:0]   diff;
        logic signed [OUTW:0]   env_sum;
        logic [OUTW-1:0]        env_next;
        logic [GAIN_W-1:0]      step;
        logic [GAIN_W-1:0]      gain_next;
        logic                   unused_sum;

        assign attack_c  = (32'(attack_shift) > MAX_ATTACK_SHIFT) ? ASW'(MAX_ATTACK_SHIFT) : attack_shift;
        assign release_c = (32'(release_shift) > MAX_RELEASE_SHIFT) ? RSW'(MAX_RELEASE_SHIFT) : release_shift;
        assign avg_c     = (32'(avg_shift) > MAX_AVG_SHIFT) ? VSW'(MAX_AVG_SHIFT) : avg_shift;

        // Channel codes beyond NR_CHANNELS read as a fresh channel and never write state.
        assign ch_ok   = 32'(ch_reg) < NR_CHANNELS;
        assign gain_rd = ch_ok ? gain_arr[ch_reg] : UNITY;
        assign env_rd  = ch_ok ? env_arr[ch_reg] : '0;

        for (genvar gi = 0; gi < NR_CHANNELS; gi++) begin : g_ch
            logic [GAIN_W-1:0] gain_reg;
            logic [OUTW-1:0]   env_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    gain_reg <= UNITY;
                    env_reg  <= '0;
                end else if (state_reg == ST_OUT && 32'(ch_reg) == gi) begin
                    gain_reg <= gain_next;
                    env_reg  <= env_next;
                end
            end

            assign gain_arr[gi] = gain_reg;
            assign env_arr[gi]  = env_reg;
        end

        always_comb begin
            p_next = PW'(s_reg) * PW'($signed({1'b0, gain_rd}));
`ifdef LIMITER_ROUND_EN
            p_rnd = p_reg + PW'(1 << (GAIN_FRAC - 1));
`else
            p_rnd = p_reg;
`endif
            p_shift = p_rnd >>> GAIN_FRAC;
        end

        limiter_sat #(.INW(PW), .OUTW(OUTW)) u_sat (
            .d (p_shift),
            .q (y)
        );

        always_comb begin
            if (y == SMIN) begin
                mag = SMAX_U;
            end else if (y[OUTW-1]) begin
                mag = unsigned'(-y);
            end else begin
                mag = unsigned'(y);
            end
            diff     = $signed({1'b0, mag}) - $signed({1'b0, env_rd});
            env_sum  = $signed({1'b0, env_rd}) + (diff >>> avg_c);
            env_next = env_sum[OUTW-1:0];

            step      = '0;
            gain_next = gain_rd;
            if (env_next > THRESHOLD) begin
                step = gain_rd >> attack_c;
                if (step == '0) step = GAIN_W'(1);
                gain_next = (gain_rd > step) ? gain_rd - step : GAIN_W'(1);
            end else if (gain_rd < UNITY) begin
                step = (UNITY - gain_rd) >> release_c;
                if (step == '0) step = GAIN_W'(1);
                gain_next = (step >= UNITY - gain_rd) ? UNITY : gain_rd + step;
            end
        end

        assign unused_sum = env_sum[OUTW];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_reg  <= ST_IDLE;
                dr_reg     <= 1'b0;
                lim_dv_reg <= 1'b0;
                lim_d_reg  <= '0;
                lim_ch_reg <= '0;
                s_reg      <= '0;
                ch_reg     <= '0;
                p_reg      <= '0;
            end else begin
                lim_dv_reg <= 1'b0;
                case (state_reg)
                    ST_IDLE: begin
                        dr_reg <= 1'b1;
                        if (signal_dv && dr_reg) begin
                            s_reg     <= signal_d;
                            ch_reg    <= signal_ch;
                            dr_reg    <= 1'b0;
                            state_reg <= ST_MUL;
                        end
                    end
                    ST_MUL: begin
                        p_reg     <= p_next;
                        state_reg <= ST_OUT;
                    end
                    ST_OUT: begin
                        lim_d_reg  <= y;
                        lim_ch_reg <= ch_reg;
                        lim_dv_reg <= 1'b1;
                        dr_reg     <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                    default: begin
                        dr_reg    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_limiter.sv
// Directed bench for audio_limiter: one saturating instance and one gain-limiting instance.
module tb_audio_limiter;

    localparam longint OMAX = 64'sd8388607;
    localparam longint OMIN = -64'sd8388608;

    logic clk = 1'b0;
    logic rst_n;

    logic signed [29:0] d0, d1;
    logic [1:0]         ch0, ch1;
    logic               dv0, dv1;
    logic               dr0, dr1;
    logic [3:0]         att, rel;
    logic [1:0]         avg;
    logic signed [23:0] lim_d0, lim_d1;
    logic [1:0]         lim_ch0, lim_ch1;
    logic               lim_dv0, lim_dv1;

    int checks = 0;
    int failures = 0;

    longint m_gain [3];
    longint m_env  [3];

    always #5 clk = ~clk;

    audio_limiter #(.NR_CHANNELS(3), .INPUT_WIDTH(30), .OUTPUT_WIDTH(24), .ATTENUATION(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .signal_d(d0), .signal_ch(ch0), .signal_dv(dv0), .signal_dr(dr0),
        .attack_shift(att), .release_shift(rel), .avg_shift(avg),
        .lim_d(lim_d0), .lim_ch(lim_ch0), .lim_dv(lim_dv0)
    );

    audio_limiter #(.NR_CHANNELS(3), .INPUT_WIDTH(30), .OUTPUT_WIDTH(24), .ATTENUATION(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .signal_d(d1), .signal_ch(ch1), .signal_dv(dv1), .signal_dr(dr1),
        .attack_shift(att), .release_shift(rel), .avg_shift(avg),
        .lim_d(lim_d1), .lim_ch(lim_ch1), .lim_dv(lim_dv1)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_gain[i] = 65536;
            m_env[i]  = 0;
        end
    endtask

    // Reference limiter: product, shift, saturate, envelope, then gain for the next sample.
    function automatic longint model_step(input int ch, input longint x);
        longint p, y, a, dlt;
        p = x * m_gain[ch];
`ifdef LIMITER_ROUND_EN
        p = p + 32768;
`endif
        y = p >>> 16;
        if (y > OMAX) y = OMAX;
        else if (y < OMIN) y = OMIN;
        a = (y == OMIN) ? OMAX : ((y < 0) ? -y : y);
        m_env[ch] = m_env[ch] + ((a - m_env[ch]) >>> int'(avg));
        if (m_env[ch] > 64'sd4194304) begin
            dlt = m_gain[ch] >> int'(att);
            if (dlt < 1) dlt = 1;
            m_gain[ch] = m_gain[ch] - dlt;
            if (m_gain[ch] < 1) m_gain[ch] = 1;
        end else if (m_gain[ch] < 65536) begin
            dlt = (65536 - m_gain[ch]) >> int'(rel);
            if (dlt < 1) dlt = 1;
            m_gain[ch] = m_gain[ch] + dlt;
            if (m_gain[ch] > 65536) m_gain[ch] = 65536;
        end
        return y;
    endfunction

    task automatic send0(input longint x, input logic [1:0] ch, input longint exp);
        @(negedge clk);
        check("sat_ready", dr0, 1'b1);
        d0 = 30'(x); ch0 = ch; dv0 = 1'b1;
        @(negedge clk);
        dv0 = 1'b0;
        check("sat_dv", lim_dv0, 1'b1);
        check("sat_data", lim_d0, exp);
        check("sat_ch", lim_ch0, ch);
        $display("TXN sat ch=%0d in=%0d out=%0d exp=%0d", ch, x, lim_d0, exp);
        @(negedge clk);
        check("sat_dv_pulse", lim_dv0, 1'b0);
    endtask

    // junk keeps signal_dv high with other data while the limiter is busy.
    task automatic send1(input longint x, input logic [1:0] ch, input bit verbose, input bit junk);
        longint exp;
        exp = model_step(int'(ch), x);
        @(negedge clk);
        check("lim_ready", dr1, 1'b1);
        d1 = 30'(x); ch1 = ch; dv1 = 1'b1;
        @(negedge clk);
        if (junk) begin
            d1 = 30'sh1FFFFFFF; ch1 = 2'd0;
        end else begin
            dv1 = 1'b0;
        end
        check("lim_busy1", dr1, 1'b0);
        check("lim_early1", lim_dv1, 1'b0);
        @(negedge clk);
        dv1 = 1'b0;
        check("lim_busy2", dr1, 1'b0);
        check("lim_early2", lim_dv1, 1'b0);
        @(negedge clk);
        check("lim_latency", lim_dv1, 1'b1);
        check("lim_ready_back", dr1, 1'b1);
        check("lim_data", lim_d1, exp);
        check("lim_ch", lim_ch1, ch);
        if (verbose) $display("TXN gain ch=%0d in=%0d out=%0d exp=%0d", ch, x, lim_d1, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        d0 = '0; ch0 = '0; dv0 = 1'b0;
        d1 = '0; ch1 = '0; dv1 = 1'b0;
        att = 4'd6; rel = 4'd10; avg = 2'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_dr0", dr0, 1'b0);
        check("rst_dv0", lim_dv0, 1'b0);
        check("rst_d0", lim_d0, 0);
        check("rst_dr1", dr1, 1'b0);
        check("rst_dv1", lim_dv1, 1'b0);
        check("rst_d1", lim_d1, 0);
        check("rst_ch1", lim_ch1, 2'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send0(64'sd1048576, 2'd2, 64'sd1048576);
        send0(64'sd536870911, 2'd0, OMAX);
        send0(-64'sd536870912, 2'd1, OMIN);
        send0(-64'sd5, 2'd2, -64'sd5);
        send0(64'sd8388608, 2'd1, OMAX);

        send1(64'sd1000, 2'd0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++) send1(64'sd536870911, 2'd0, 1'b0, 1'b0);
        $display("TXN gain attack phase ch=0 samples=600 last_out=%0d", lim_d1);
        check("settle_lo", lim_d1 > 24'sd2097152, 1'b1);
        check("settle_hi", lim_d1 < 24'sd8388607, 1'b1);

        send1(64'sd1000, 2'd1, 1'b1, 1'b0);
        send1(-64'sd3000, 2'd2, 1'b1, 1'b0);

        rel = 4'd7;
        for (int i = 0; i < 5000; i++) send1(64'sd0, 2'd0, 1'b0, 1'b0);
        $display("TXN gain release phase ch=0 samples=5000 last_out=%0d", lim_d1);
        send1(64'sd1048576, 2'd0, 1'b1, 1'b0);

        send1(-64'sd3000, 2'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_dv", lim_dv1, 1'b0);
        end
        send1(64'sd1048576, 2'd0, 1'b1, 1'b0);

        // Abort a sample in flight with reset.
        @(negedge clk);
        d1 = 30'sd777; ch1 = 2'd1; dv1 = 1'b1;
        @(negedge clk);
        dv1 = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dv_a", lim_dv1, 1'b0);
        check("midrst_dr", dr1, 1'b0);
        @(negedge clk);
        check("midrst_dv_b", lim_dv1, 1'b0);
        check("midrst_d", lim_d1, 0);
        check("midrst_ch", lim_ch1, 2'd0);
        rst_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("midrst_no_out", lim_dv1, 1'b0);
        send1(64'sd1000, 2'd0, 1'b1, 1'b0);
        send0(64'sd1048576, 2'd2, 64'sd1048576);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
